// File: rtl/token_shift_chain.sv
// rtl/token_shift_chain.sv - control-token delay line with per-stage valid and segment length tracking
// Stage 0 valid doubles as the segment-open flag for the input-side counter.
module token_shift_chain #(
  parameter int                TOK_W     = 3,
  parameter int                DEPTH     = 1,
  parameter int                CNT_W     = 8,
  parameter logic [TOK_W-1:0]  TOK_START = TOK_W'(3'b001),
  parameter logic [TOK_W-1:0]  TOK_END   = TOK_W'(3'b010)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [TOK_W-1:0] t_in,
  output logic [TOK_W-1:0] t_o,
  output logic             valid,
  output logic [CNT_W-1:0] seg_len,
  output logic             seg_done,
  output logic             seg_sat,
  output logic             proto_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [TOK_W-1:0] tok_q [DEPTH];
  logic [DEPTH-1:0] val_q;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             is_start;
  logic             is_end;
  logic             seg_open;
  logic             v_next;

  assign is_start = (t_in == TOK_START);
  assign is_end   = (t_in == TOK_END);
  assign seg_open = val_q[0];

  always_comb begin
    v_next = seg_open;
    if (is_start)    v_next = 1'b1;
    else if (is_end) v_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) tok_q[k] <= '0;
      val_q <= '0;
    end else if (en) begin
      tok_q[0] <= t_in;
      val_q[0] <= v_next;
      for (int k = 1; k < DEPTH; k++) begin
        tok_q[k] <= tok_q[k-1];
        val_q[k] <= val_q[k-1];
      end
    end
  end

  assign t_o   = tok_q[DEPTH-1];
  assign valid = val_q[DEPTH-1];

  // Pulses are cleared every cycle, so a stall also drops them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sat       <= 1'b0;
      seg_len   <= '0;
      seg_sat   <= 1'b0;
      seg_done  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      seg_done  <= 1'b0;
      proto_err <= 1'b0;
      if (en) begin
        if (is_start) begin
          proto_err <= seg_open;
          cnt       <= CNT_ONE;
          sat       <= 1'b0;
        end else if (is_end) begin
          if (seg_open) begin
            seg_len  <= cnt;
            seg_sat  <= sat;
            seg_done <= 1'b1;
            cnt      <= '0;
            sat      <= 1'b0;
          end else begin
            proto_err <= 1'b1;
          end
        end else if (seg_open) begin
          if (cnt == CNT_MAX) sat <= 1'b1;
          else                cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

endmodule
